// File: rtl/imem_loader.sv
// imem_loader: byte-stream boot loader for the instruction memory.
// Stream format: N[7:0], N[15:8], then N little-endian 32-bit words (4 bytes each).
// Words are written into memory at BASE_ADDR + 4*i. While loading, cpu_hold keeps
// the core stalled.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN. When it is defined, one extra
// byte follows the last word. That byte must equal the XOR of all data bytes.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] mem_waddress,
    output logic [31:0] mem_datain,
    output logic        mem_wr,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE, S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    localparam logic [15:0] MAXW = 16'(MAX_WORDS);

    state_t      state, state_n;
    logic [15:0] n;
    logic [31:0] word;
    logic [1:0]  bidx;
    logic [15:0] len_full;
    logic        xfer;
    logic        restart;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    // The full length is formed from the latched low byte and the current high byte.
    // This lets LEN1 decide the next state in the same cycle it accepts the byte.
    assign len_full = {byte_in, n[7:0]};
    assign xfer     = byte_valid & byte_ready;
    assign restart  = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state and Moore outputs
    always_comb begin
        state_n    = state;
        byte_ready = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_n = S_LEN0;
            end
            S_LEN0: begin
                byte_ready = 1'b1;
                if (byte_valid) state_n = S_LEN1;
            end
            S_LEN1: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    if (len_full == 16'd0)      state_n = S_DONE;
                    else if (len_full > MAXW)   state_n = S_ERR;
                    else                        state_n = S_DATA;
                end
            end
            S_DATA: begin
                byte_ready = 1'b1;
                if (byte_valid && bidx == 2'd3) state_n = S_WRITE;
            end
            S_WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_n = (word_count + 16'd1 == n) ? S_CSUM : S_DATA;
`else
                state_n = (word_count + 16'd1 == n) ? S_DONE : S_DATA;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                byte_ready = 1'b1;
                if (byte_valid) state_n = (byte_in == csum) ? S_DONE : S_ERR;
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    // Session datapath: length, byte assembly, word counter and running checksum
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            n          <= '0;
            word       <= '0;
            bidx       <= '0;
            word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else if (restart) begin
            n          <= '0;
            bidx       <= '0;
            word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            if (xfer && state == S_LEN0) n[7:0]  <= byte_in;
            if (xfer && state == S_LEN1) n[15:8] <= byte_in;
            if (xfer && state == S_DATA) begin
                word[{bidx, 3'b000} +: 8] <= byte_in;
                bidx                      <= bidx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum                      <= csum ^ byte_in;
`endif
            end
            if (state == S_WRITE) word_count <= word_count + 16'd1;
        end
    end

    // The address tracks word_count. It equals BASE_ADDR after reset and wraps modulo 2^32.
    assign mem_waddress = BASE_ADDR + {14'd0, word_count, 2'b00};
    assign mem_wr       = (state == S_WRITE);
    assign mem_datain   = (state == S_WRITE) ? word : 32'd0;
    assign cpu_hold     = (state != S_DONE);
    assign done         = (state == S_DONE);
    assign error        = (state == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader.
// The reference model turns a list of words into the byte stream. It then expects
// one write per word at BASE + 4*i.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [31:0] mem_waddress;
    logic [31:0] mem_datain;
    logic        mem_wr;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clock(clock), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready),
        .mem_waddress(mem_waddress), .mem_datain(mem_datain), .mem_wr(mem_wr),
        .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    // Record every memory write strobe, sampled away from the rising edge
    always @(negedge clock) begin
        if (reset && mem_wr) begin
            wr_addr_q.push_back(mem_waddress);
            wr_data_q.push_back(mem_datain);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gapmax);
        int cnt;
        repeat ($urandom_range(gapmax, 0)) tick;
        byte_in    = b;
        byte_valid = 1'b1;
        cnt = 0;
        while (!byte_ready && cnt < 50) begin
            tick;
            cnt++;
        end
        if (!byte_ready) chk("byte_ready_timeout", 32'(byte_ready), 32'd1);
        tick;
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
    endtask

    // Full load session: the model checks for one write per word, in order, and a final done.
    task automatic run_session(input logic [31:0] words[$], input int gapmax,
                               input bit midstart, input string tag);
        int   nw;
        int   cnt;
        logic [7:0] x;
        nw = words.size();
        x  = 8'h00;
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start;
        send_byte(8'(nw), gapmax);
        send_byte(8'(nw >> 8), gapmax);
        for (int i = 0; i < nw; i++) begin
            for (int k = 0; k < 4; k++) begin
                send_byte(8'(words[i] >> (8 * k)), gapmax);
                x = x ^ 8'(words[i] >> (8 * k));
                if (midstart && i == 0 && k == 1) pulse_start;
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(x, gapmax);
`endif
        cnt = 0;
        while (!(done || error) && cnt < 40) begin
            tick;
            cnt++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_word_count"}, 32'(word_count), 32'(nw));
        chk({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(nw));
        for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], BASE + 32'(4 * i));
            chk($sformatf("%s_data%0d", tag, i), wr_data_q[i], words[i]);
        end
    endtask

    initial begin
        logic [31:0] w[$];
        int nw;

        // 1: out of reset, without a start, the core stays held and the loader ignores bytes
        repeat (3) tick;
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_addr", mem_waddress, BASE);
        chk("rst_datain", mem_datain, 32'd0);
        reset = 1'b1;
        byte_valid = 1'b1;
        byte_in = 8'hA5;
        repeat (20) tick;
        chk("idle_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_byte_ready", 32'(byte_ready), 32'd0);
        chk("idle_word_count", 32'(word_count), 32'd0);
        chk("idle_nwrites", 32'(wr_addr_q.size()), 32'd0);
        byte_valid = 1'b0;
        tick;

        // 2: directed two-word program
        w = '{32'h00400513, 32'h00150593};
        run_session(w, 0, 1'b0, "dir");

        // 3: zero length goes straight to done without writing
        wr_addr_q.delete();
        pulse_start;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("n0_done", 32'(done), 32'd1);
        chk("n0_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("n0_word_count", 32'(word_count), 32'd0);
        repeat (3) tick;
        chk("n0_nwrites", 32'(wr_addr_q.size()), 32'd0);

        // 4: oversize length errors out, stays sticky, then a fresh start loads normally
        wr_addr_q.delete();
        pulse_start;
        send_byte(8'(MAXW + 1), 0);
        send_byte(8'((MAXW + 1) >> 8), 0);
        chk("big_error", 32'(error), 32'd1);
        chk("big_cpu_hold", 32'(cpu_hold), 32'd1);
        byte_valid = 1'b1;
        repeat (5) tick;
        byte_valid = 1'b0;
        chk("big_sticky", 32'(error), 32'd1);
        chk("big_byte_ready", 32'(byte_ready), 32'd0);
        chk("big_nwrites", 32'(wr_addr_q.size()), 32'd0);
        w = '{32'hDEADBEEF, 32'h12345678, 32'h0BADF00D};
        run_session(w, 1, 1'b0, "after_err");

        // 5: gaps between bytes must not change the writes
        w = '{32'h00400513, 32'h00150593};
        run_session(w, 5, 1'b0, "gap");

        // 5b: a reset mid-word discards the partial word
        wr_addr_q.delete();
        pulse_start;
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 2);
        send_byte(8'h05, 2);
        reset = 1'b0;
        #1;
        chk("mrst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("mrst_mem_wr", 32'(mem_wr), 32'd0);
        chk("mrst_word_count", 32'(word_count), 32'd0);
        tick;
        reset = 1'b1;
        byte_valid = 1'b1;
        repeat (6) tick;
        byte_valid = 1'b0;
        chk("mrst_idle_ready", 32'(byte_ready), 32'd0);
        chk("mrst_idle_hold", 32'(cpu_hold), 32'd1);
        chk("mrst_idle_done", 32'(done), 32'd0);
        chk("mrst_nwrites", 32'(wr_addr_q.size()), 32'd0);

        // Random sessions. Some of them pulse start mid-stream, and that pulse must be ignored.
        for (int s = 0; s < 8; s++) begin
            w.delete();
            nw = $urandom_range(6, 1);
            for (int i = 0; i < nw; i++) w.push_back($urandom);
            run_session(w, $urandom_range(3, 0), s[0], $sformatf("rnd%0d", s));
        end

        // Largest accepted length
        w.delete();
        for (int i = 0; i < MAXW; i++) w.push_back($urandom);
        run_session(w, 0, 1'b0, "max");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // A wrong checksum leaves the words written but flags an error
        wr_addr_q.delete();
        pulse_start;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        foreach (w[i]) if (i < 2) for (int k = 0; k < 4; k++) send_byte(8'(w[i] >> (8 * k)), 0);
        send_byte(8'(w[0] ^ (w[0] >> 8) ^ (w[0] >> 16) ^ (w[0] >> 24) ^
                      w[1] ^ (w[1] >> 8) ^ (w[1] >> 16) ^ (w[1] >> 24)) ^ 8'hFF, 0);
        chk("csum_bad_error", 32'(error), 32'd1);
        chk("csum_bad_hold", 32'(cpu_hold), 32'd1);
        chk("csum_bad_nwrites", 32'(wr_addr_q.size()), 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
